// File: rtl/wb_scoreboard_arbiter.sv
// Writeback scheduler for the integer core: a register scoreboard that gates issue on
// RAW/WAW hazards, plus a round-robin arbiter that shares the single regfile write port.
module wb_scoreboard_arbiter #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NUM_FU = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rs1,
    input  logic [4:0]             issue_rs2,
    input  logic [4:0]             issue_rd,
    output logic                   issue_ready,
    input  logic [NUM_FU-1:0]      wb_valid,
    input  logic [NUM_FU*5-1:0]    wb_rd,
    input  logic [NUM_FU*XLEN-1:0] wb_data,
    output logic [NUM_FU-1:0]      wb_ready,
    output logic                   reg_write_en,
    output logic [4:0]             reg_write_sel,
    output logic [XLEN-1:0]        reg_write_data,
    output logic [31:0]            pending
);

    localparam int unsigned PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_nxt;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            issue_fire;
    logic            wb_write;
    logic [31:0]     pend_nxt;
    int unsigned     scan_idx;

    // pending[0] is never set, so x0 operands and x0 destinations never stall.
    assign issue_ready = !flush && !pending[issue_rs1] && !pending[issue_rs2]
                         && !pending[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        wb_ready  = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NUM_FU;
            if (!grant_vld && wb_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(scan_idx);
            end
        end
        if (grant_vld) begin
            wb_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_rd   = wb_rd[32'(grant_idx) * 5 +: 5];
    assign grant_data = wb_data[32'(grant_idx) * XLEN +: XLEN];
    assign wb_write   = grant_vld && (grant_rd != 5'd0);

    always_comb begin
        rr_nxt = rr_ptr;
        if (flush) begin
            rr_nxt = '0;
        end else if (grant_vld) begin
            rr_nxt = (32'(grant_idx) + 32'd1 == NUM_FU) ? '0 : grant_idx + 1'b1;
        end
    end

    // Clear before set so an issue to the same rd wins; flush overrides both.
    always_comb begin
        pend_nxt = pending;
        if (wb_write) begin
            pend_nxt[grant_rd] = 1'b0;
        end
        if (issue_fire) begin
            pend_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            pend_nxt = '0;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending        <= '0;
            rr_ptr         <= '0;
            reg_write_en   <= 1'b0;
            reg_write_sel  <= '0;
            reg_write_data <= '0;
        end else begin
            pending      <= pend_nxt;
            rr_ptr       <= rr_nxt;
            reg_write_en <= wb_write;
            if (wb_write) begin
                reg_write_sel  <= grant_rd;
                reg_write_data <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Bench for wb_scoreboard_arbiter: directed scenarios plus random traffic against a
// queue-based model of the FUs and the scoreboard; register writes checked by a monitor.
`timescale 1ns/1ps
module tb_wb_scoreboard_arbiter;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NUM_FU = 3;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic                   issue_valid = 1'b0;
    logic [4:0]             issue_rs1 = '0;
    logic [4:0]             issue_rs2 = '0;
    logic [4:0]             issue_rd = '0;
    logic                   issue_ready;
    logic [NUM_FU-1:0]      wb_valid = '0;
    logic [NUM_FU*5-1:0]    wb_rd = '0;
    logic [NUM_FU*XLEN-1:0] wb_data = '0;
    logic [NUM_FU-1:0]      wb_ready;
    logic                   reg_write_en;
    logic [4:0]             reg_write_sel;
    logic [XLEN-1:0]        reg_write_data;
    logic [31:0]            pending;

    wb_scoreboard_arbiter #(.XLEN(XLEN), .NUM_FU(NUM_FU)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .reg_write_en(reg_write_en), .reg_write_sel(reg_write_sel),
        .reg_write_data(reg_write_data), .pending(pending)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] mp = '0;
    int   rr = 0;
    bit   exp_we = 1'b0;
    res_t fu_q[NUM_FU][$];
    res_t exp_wq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int backlog();
        int s = 0;
        for (int f = 0; f < NUM_FU; f++) s += fu_q[f].size();
        return s;
    endfunction

    task automatic push_fu(input int f, input logic [4:0] rd, input logic [XLEN-1:0] d);
        res_t r;
        r.rd = rd;
        r.data = d;
        fu_q[f].push_back(r);
    endtask

    task automatic drive_fus();
        wb_valid = '0;
        wb_rd    = '0;
        wb_data  = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (fu_q[f].size() != 0) begin
                wb_valid[f]               = 1'b1;
                wb_rd[f*5 +: 5]           = fu_q[f][0].rd;
                wb_data[f*XLEN +: XLEN]   = fu_q[f][0].data;
            end
        end
    endtask

    // Called at posedge+1; samples at the falling edge and advances the model one cycle.
    task automatic step(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit fl, input int fu_sel,
                        input logic [XLEN-1:0] d);
        bit                exp_rdy;
        int                g;
        logic [NUM_FU-1:0] exp_wr;
        res_t              r;
        issue_valid = iv;
        issue_rs1   = r1;
        issue_rs2   = r2;
        issue_rd    = rd;
        flush       = fl;
        drive_fus();
        #4;
        exp_rdy = !fl && !mp[r1] && !mp[r2] && !mp[rd];
        g = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            int f = (rr + k) % NUM_FU;
            if (g < 0 && fu_q[f].size() != 0) g = f;
        end
        exp_wr = '0;
        if (g >= 0) exp_wr[g] = 1'b1;
        chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
        chk("wb_ready", 64'(wb_ready), 64'(exp_wr));
        chk("pending", 64'(pending), 64'(mp));
        chk("reg_write_en", 64'(reg_write_en), 64'(exp_we));
        exp_we = 1'b0;
        if (g >= 0) begin
            r = fu_q[g].pop_front();
            if (r.rd != 5'd0) begin
                exp_wq.push_back(r);
                mp[r.rd] = 1'b0;
                exp_we = 1'b1;
            end
            rr = (g + 1) % NUM_FU;
        end
        if (iv && exp_rdy) begin
            if (rd != 5'd0) mp[rd] = 1'b1;
            if (fu_sel >= 0) push_fu(fu_sel, rd, d);
        end
        if (fl) begin
            mp = '0;
            rr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, -1, '0);
    endtask

    // Write-port monitor: every strobe must match the oldest granted result.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst && reg_write_en) begin
                chk("write_expected", 64'(exp_wq.size() != 0), 64'd1);
                if (exp_wq.size() != 0) begin
                    r = exp_wq.pop_front();
                    chk("write_sel", 64'(reg_write_sel), 64'(r.rd));
                    chk("write_data", reg_write_data, r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_write_en", 64'(reg_write_en), 64'd0);
        chk("rst_sel", 64'(reg_write_sel), 64'd0);
        chk("rst_data", reg_write_data, 64'd0);
        rst = 1'b1;
        #4;
        chk("post_rst_pending", 64'(pending), 64'd0);
        chk("post_rst_write_en", 64'(reg_write_en), 64'd0);
        chk("post_rst_issue_ready", 64'(issue_ready), 64'd1);
        @(posedge clk);
        #1;

        // RAW stall on x3 until FU0 writes it back.
        step(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, -1, '0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, -1, '0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, -1, '0);
        push_fu(0, 5'd3, 64'h3355448966A9EFED);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, -1, '0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, -1, '0);
        idle();

        // Round-robin with all FUs valid from rr_ptr=0.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, -1, '0);
        for (int i = 1; i <= 6; i++) step(1'b1, 5'd0, 5'd0, 5'(i), 1'b0, -1, '0);
        for (int i = 1; i <= 6; i++) push_fu((i - 1) % NUM_FU, 5'(i), {$urandom, $urandom});
        repeat (8) idle();

        // x0 destination: no scoreboard entry, consumed without a write.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1, {$urandom, $urandom});
        idle();
        idle();

        // Flush with x5/x9 pending and FU2 returning x5 in the flush cycle.
        step(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, -1, '0);
        step(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, -1, '0);
        push_fu(2, 5'd5, {$urandom, $urandom});
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, -1, '0);
        idle();
        idle();

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            bit fl;
            fl = (backlog() <= 1) && ($urandom_range(0, 31) == 0);
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), fl, int'($urandom_range(0, NUM_FU - 1)),
                 {$urandom, $urandom});
        end
        n = 0;
        while (backlog() != 0 && n < 200) begin
            idle();
            n++;
        end
        idle();
        chk("drain_backlog", 64'(backlog()), 64'd0);
        chk("drain_writes", 64'(exp_wq.size()), 64'd0);

        // Async reset between edges with a write in flight and two FUs valid.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, -1, '0);
        step(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, -1, '0);
        step(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, -1, '0);
        step(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, -1, '0);
        push_fu(0, 5'd10, {$urandom, $urandom});
        push_fu(0, 5'd12, {$urandom, $urandom});
        push_fu(1, 5'd11, {$urandom, $urandom});
        idle();
        drive_fus();
        chk("pre_reset_valid", 64'(wb_valid), 64'b011);
        #1;
        rst = 1'b0;
        #1;
        chk("async_write_en", 64'(reg_write_en), 64'd0);
        chk("async_sel", 64'(reg_write_sel), 64'd0);
        chk("async_data", reg_write_data, 64'd0);
        chk("async_pending", 64'(pending), 64'd0);
        for (int f = 0; f < NUM_FU; f++) fu_q[f].delete();
        exp_wq.delete();
        drive_fus();
        mp = '0;
        rr = 0;
        exp_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) idle();
        step(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1, {$urandom, $urandom});
        repeat (3) idle();
        chk("final_writes", 64'(exp_wq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
